add_serial_ctrl: RTL
====================

Name: add_serial_ctrl

Overview:
Sequencer that feeds the 8-bit serial adder and collects its result. Operand pairs arrive on a valid/ready stream and are buffered in a small FIFO. Each pair is launched into the adder with a one-cycle add_en pulse. After a fixed latency, add_out is captured and presented on a valid/ready result stream.

Parameters:
WIDTH, 8, operand and result width; must match the serial adder.
DEPTH, 4, operand FIFO depth; power of 2, 2..16.
LATENCY, 10, cycles from the add_en pulse to the edge on which add_out is sampled; range 2..255.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  FIFO can accept; equals !full.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
add_en  output  1  start pulse to the adder (its en).
add_a  output  WIDTH  operand A to the adder; registered.
add_b  output  WIDTH  operand B to the adder; registered.
add_out  input  WIDTH  result from the adder (its out).
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_sum  output  WIDTH  captured result.
busy  output  1  FSM not in IDLE.
fifo_count  output  clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE; FIFO empty, so fifo_count=0 and in_ready=1. add_en=0, add_a=0, add_b=0, out_valid=0, out_sum=0, busy=0, wait counter=0.
- Push: a push occurs when in_valid && in_ready. The FIFO stores {in_a,in_b}. Pointers wrap modulo DEPTH.
- in_ready depends only on full. A push is refused when full even if a pop happens in the same cycle.
- Simultaneous push and pop while not full: fifo_count is unchanged.
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
- IDLE: if the FIFO is not empty, go to LAUNCH next cycle.
- LAUNCH (exactly 1 cycle):
  - add_en=1.
  - add_a/add_b take the FIFO head at this same clock edge, i.e. registered on the IDLE->LAUNCH edge, so they are valid while add_en=1.
  - Pop the head. Load the wait counter with LATENCY-1. Go to WAIT.
- add_a/add_b hold their values from LAUNCH until the next LAUNCH.
- WAIT: decrement the counter each cycle. On the edge where the counter is 0:
  - out_sum<=add_out, out_valid<=1.
  - Go to HOLD.
  - The add_out sample edge therefore falls LATENCY cycles after the add_en=1 cycle.
- HOLD: out_valid=1 and out_sum is stable.
  - On out_valid && out_ready: clear out_valid.
  - If the FIFO is not empty (evaluated that cycle), go directly to LAUNCH; otherwise go to IDLE.
- Throughput: one result per LATENCY+2 cycles with out_ready held high.
- Width rules: out_sum is WIDTH bits as delivered by the adder. No carry-out is produced; wrap-around is the adder's concern.
- busy=1 in LAUNCH, WAIT and HOLD.
- add_en is never asserted outside LAUNCH.
- Reset mid-operation (any state) returns everything to reset values and discards FIFO contents and any in-flight result. No output pulse is generated.
- in_valid is honoured in every FSM state; buffering is independent of the FSM.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/LAUNCH/WAIT/HOLD, 2 bits).
  - Default WIDTH/DEPTH/LATENCY constants.
  - A clog2-based count-width function.
- One sub-module: add_serial_fifo. It is a synchronous FIFO with:
  - parameters WIDTH and DEPTH;
  - ports push, pop, din, dout (head, combinational), full, empty, count;
  - the same clk/rst_n.
- The FSM and result register stay in add_serial_ctrl.

Test Plan:
- Reset then single op: push (0x12,0x34); the behavioural adder model returns a+b.
  - add_en is high for exactly 1 cycle, with add_a=0x12 and add_b=0x34.
  - out_valid rises LATENCY+1 cycles after add_en, with out_sum=0x46.
- Overflow wrap: (0xFF,0x01) -> out_sum=0x00; (0x80,0x80) -> 0x00; (0xF0,0x0F) -> 0xFF.
- FIFO fill with out_ready=0, DEPTH=4: push 6 pairs back-to-back.
  - in_ready drops once fifo_count reaches 4.
  - Exactly 5 pairs are accepted in total: 1 launched, 4 buffered.
  - With out_ready released, results emerge in order; spacing is LATENCY+2 cycles.
- Backpressure in HOLD: hold out_ready=0 for 20 cycles.
  - out_valid and out_sum stay stable.
  - No further add_en pulses occur.
- Reset mid-WAIT: assert rst_n=0 for 1 cycle at counter=3.
  - All outputs return to 0, fifo_count=0, in_ready=1.
  - No out_valid follows.
- Simultaneous push and pop at fifo_count=2 on the LAUNCH edge: fifo_count stays 2 and ordering is preserved.

Source files
------------

// File: rtl/add_serial_ctrl_pkg.sv
// Shared definitions for the serial-adder sequencer.
// Provides the controller state encoding, default parameter values and
// a helper that sizes occupancy counters.
package add_serial_ctrl_pkg;

    // Controller states. The encoding is fixed so that waveforms stay comparable across revisions.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } ctrl_state_e;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_LATENCY = 10;

    // The wait counter must hold LATENCY-1 for LATENCY up to 255.
    localparam int WAIT_CNT_W  = 8;

    // Width needed to represent an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/add_serial_fifo.sv
// Synchronous operand FIFO.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   push, din  : write request and data. Writes are ignored while the FIFO is full.
//   pop        : read request. Reads are ignored while the FIFO is empty.
//   dout       : current head entry (combinational)
//   full, empty: occupancy flags
//   count      : current occupancy
module add_serial_fifo
    import add_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              dout,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty_s   = (count_r == CNT_W'(0));
    assign push_ok_s = push && !full_s;
    assign pop_ok_s  = pop && !empty_s;

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

    // Storage array and write pointer. DEPTH is a power of two, so the pointer wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Read pointer advances on an accepted pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
        end else if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_r <= rd_ptr_r;
        end
    end

    // Occupancy counter. A simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/add_serial_ctrl.sv
// Sequencer for an external serial adder.
// Operand pairs are buffered in a FIFO. Each pair is launched with a
// one-cycle add_en pulse. add_out is sampled LATENCY cycles later and
// presented on a valid/ready result stream.
// Ports:
//   clk, rst_n                 : clock and asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b: operand stream (in_ready = FIFO not full)
//   add_en/add_a/add_b         : registered launch interface to the adder
//   add_out                    : adder result
//   out_valid/out_ready/out_sum: result stream
//   busy                       : controller not idle
//   fifo_count                 : operand FIFO occupancy
module add_serial_ctrl
    import add_serial_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_a,
    input  logic [WIDTH-1:0]              in_b,
    output logic                          add_en,
    output logic [WIDTH-1:0]              add_a,
    output logic [WIDTH-1:0]              add_b,
    input  logic [WIDTH-1:0]              add_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_sum,
    output logic                          busy,
    output logic [count_width(DEPTH)-1:0] fifo_count
);

    // The counter is loaded in LAUNCH and the sample happens on the edge
    // where it reads zero. The sample therefore lands LATENCY edges after the add_en cycle.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(LATENCY - 1);

    ctrl_state_e             state_r;
    ctrl_state_e             state_nxt_s;
    logic [WAIT_CNT_W-1:0]   wait_cnt_r;
    logic                    add_en_r;
    logic [WIDTH-1:0]        add_a_r;
    logic [WIDTH-1:0]        add_b_r;
    logic                    out_valid_r;
    logic [WIDTH-1:0]        out_sum_r;

    logic                    launch_s;
    logic                    pop_s;
    logic                    capture_s;
    logic                    release_s;

    logic [2*WIDTH-1:0]      fifo_dout_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;

    add_serial_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (pop_s),
        .din   ({in_a, in_b}),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count)
    );

    assign in_ready  = !fifo_full_s;
    assign add_en    = add_en_r;
    assign add_a     = add_a_r;
    assign add_b     = add_b_r;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign busy      = (state_r != ST_IDLE);

    // Next-state logic and the one-cycle action strobes.
    always_comb begin
        state_nxt_s = state_r;
        launch_s    = 1'b0;
        pop_s       = 1'b0;
        capture_s   = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = ST_LAUNCH;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                // The head was copied into add_a/add_b on entry, so it can be dropped now.
                state_nxt_s = ST_WAIT;
                pop_s       = 1'b1;
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_CNT_W'(0)) begin
                    state_nxt_s = ST_HOLD;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    release_s = 1'b1;
                    if (!fifo_empty_s) begin
                        state_nxt_s = ST_LAUNCH;
                        launch_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Launch interface. The operands are registered on the edge into LAUNCH and held until the next launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_en_r <= 1'b0;
            add_a_r  <= '0;
            add_b_r  <= '0;
        end else if (launch_s) begin
            add_en_r <= 1'b1;
            add_a_r  <= fifo_dout_s[2*WIDTH-1:WIDTH];
            add_b_r  <= fifo_dout_s[WIDTH-1:0];
        end else begin
            add_en_r <= 1'b0;
            add_a_r  <= add_a_r;
            add_b_r  <= add_b_r;
        end
    end

    // Latency counter. It is loaded in LAUNCH and counts down to zero in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (state_r == ST_LAUNCH) begin
            wait_cnt_r <= WAIT_LOAD;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != WAIT_CNT_W'(0))) begin
            wait_cnt_r <= wait_cnt_r - WAIT_CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Result register and valid flag for the output stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_sum_r   <= '0;
        end else if (capture_s) begin
            out_valid_r <= 1'b1;
            out_sum_r   <= add_out;
        end else if (release_s) begin
            out_valid_r <= 1'b0;
            out_sum_r   <= out_sum_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_sum_r   <= out_sum_r;
        end
    end

endmodule
